// File: rtl/control_fsm.sv
// control_fsm: multicycle sequencer for the 16-bit datapath (selects, enables, memory strobes).
// Latency: 3-5 cycles per instruction; outputs decode from the state register and opcode fields.
// No backpressure: it free-runs; build with CTRL_HALT_EN for a sticky halt on illegal encodings.
module control_fsm #(
  parameter int ALU_CONT_BITS    = 6,
  parameter int OP_CODE_BITS     = 4,
  parameter int EXT_OP_CODE_BITS = 4,
  parameter int REG_BITS         = 4,
  parameter int WIDTH            = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [OP_CODE_BITS-1:0]     op_code,
  input  logic [EXT_OP_CODE_BITS-1:0] ext_op_code,
  input  logic [REG_BITS-1:0]         A_index,
  input  logic [WIDTH-1:0]            psr_flags,
  output logic                        instruction_en,
  output logic                        pc_en,
  output logic [1:0]                  pc_src,
  output logic                        reg_write,
  output logic [1:0]                  reg_write_src,
  output logic                        alu_A_src,
  output logic                        alu_B_src,
  output logic [ALU_CONT_BITS-1:0]    alu_cont,
  output logic                        loading,
  output logic                        storing,
  output logic                        mem_write,
  output logic                        halted
);

  localparam logic [ALU_CONT_BITS-1:0] ALU_ADD = ALU_CONT_BITS'(0);
  localparam logic [ALU_CONT_BITS-1:0] ALU_SUB = ALU_CONT_BITS'(1);
  localparam logic [ALU_CONT_BITS-1:0] ALU_CMP = ALU_CONT_BITS'(2);
  localparam logic [ALU_CONT_BITS-1:0] ALU_AND = ALU_CONT_BITS'(3);
  localparam logic [ALU_CONT_BITS-1:0] ALU_OR  = ALU_CONT_BITS'(4);
  localparam logic [ALU_CONT_BITS-1:0] ALU_XOR = ALU_CONT_BITS'(5);
  localparam logic [ALU_CONT_BITS-1:0] ALU_MOV = ALU_CONT_BITS'(6);
  localparam logic [ALU_CONT_BITS-1:0] ALU_LSH = ALU_CONT_BITS'(7);
  localparam logic [ALU_CONT_BITS-1:0] ALU_LUI = ALU_CONT_BITS'(8);

  localparam logic [1:0] PC_ALU  = 2'd0;
  localparam logic [1:0] PC_REGB = 2'd1;
  localparam logic [1:0] PC_INC  = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;

  localparam logic [OP_CODE_BITS-1:0] OP_RTYPE = OP_CODE_BITS'(4'b0000);
  localparam logic [OP_CODE_BITS-1:0] OP_MEM   = OP_CODE_BITS'(4'b0100);
  localparam logic [OP_CODE_BITS-1:0] OP_SHIFT = OP_CODE_BITS'(4'b1000);
  localparam logic [OP_CODE_BITS-1:0] OP_CMPI  = OP_CODE_BITS'(4'b1011);
  localparam logic [OP_CODE_BITS-1:0] OP_BR    = OP_CODE_BITS'(4'b1100);
  localparam logic [OP_CODE_BITS-1:0] OP_LUI   = OP_CODE_BITS'(4'b1111);

  localparam logic [EXT_OP_CODE_BITS-1:0] EXT_LD    = EXT_OP_CODE_BITS'(4'b0000);
  localparam logic [EXT_OP_CODE_BITS-1:0] EXT_ST    = EXT_OP_CODE_BITS'(4'b0100);
  localparam logic [EXT_OP_CODE_BITS-1:0] EXT_JAL   = EXT_OP_CODE_BITS'(4'b1000);
  localparam logic [EXT_OP_CODE_BITS-1:0] EXT_JCOND = EXT_OP_CODE_BITS'(4'b1100);
  localparam logic [EXT_OP_CODE_BITS-1:0] EXT_CMP   = EXT_OP_CODE_BITS'(4'b1011);

  typedef enum logic [3:0] {
    S_FETCH, S_LATCH, S_DECODE, S_EXEC, S_LD, S_LD_WB,
    S_ST, S_JAL, S_JCOND, S_BR, S_HALT
  } state_t;

  state_t state;

  // R-type ext codes and immediate opcodes share one encoding of the ALU operations.
  function automatic logic [ALU_CONT_BITS:0] alu_decode(input logic [3:0] code);
    case (code)
      4'b0101: alu_decode = {1'b1, ALU_ADD};
      4'b1001: alu_decode = {1'b1, ALU_SUB};
      4'b1011: alu_decode = {1'b1, ALU_CMP};
      4'b0001: alu_decode = {1'b1, ALU_AND};
      4'b0010: alu_decode = {1'b1, ALU_OR};
      4'b0011: alu_decode = {1'b1, ALU_XOR};
      4'b1101: alu_decode = {1'b1, ALU_MOV};
      default: alu_decode = '0;
    endcase
  endfunction

  logic [ALU_CONT_BITS:0]   r_dec;
  logic [ALU_CONT_BITS:0]   i_dec;
  logic                     is_rtype;
  logic                     is_imm;
  logic                     is_shift;
  logic                     is_alu;
  logic                     is_ld;
  logic                     is_st;
  logic                     is_jal;
  logic                     is_jcond;
  logic                     is_br;
  logic                     is_cmp;
  logic                     legal;
  logic [ALU_CONT_BITS-1:0] exec_alu;
  logic                     cond_true;
  logic                     flag_z;
  logic                     flag_n;
  logic                     unused_flags;

  assign r_dec    = alu_decode(ext_op_code);
  assign i_dec    = (op_code == OP_LUI) ? {1'b1, ALU_LUI} : alu_decode(op_code);
  assign is_rtype = (op_code == OP_RTYPE) && r_dec[ALU_CONT_BITS];
  assign is_imm   = i_dec[ALU_CONT_BITS];
  assign is_shift = (op_code == OP_SHIFT);
  assign is_alu   = is_rtype || is_imm || is_shift;
  assign is_ld    = (op_code == OP_MEM) && (ext_op_code == EXT_LD);
  assign is_st    = (op_code == OP_MEM) && (ext_op_code == EXT_ST);
  assign is_jal   = (op_code == OP_MEM) && (ext_op_code == EXT_JAL);
  assign is_jcond = (op_code == OP_MEM) && (ext_op_code == EXT_JCOND);
  assign is_br    = (op_code == OP_BR);
  assign is_cmp   = (is_rtype && (ext_op_code == EXT_CMP)) || (op_code == OP_CMPI);
  assign legal    = is_alu || is_ld || is_st || is_jal || is_jcond || is_br;

  assign exec_alu = is_rtype ? r_dec[ALU_CONT_BITS-1:0] :
                    is_shift ? ALU_LSH : i_dec[ALU_CONT_BITS-1:0];

  assign flag_z       = psr_flags[6];
  assign flag_n       = psr_flags[7];
  assign unused_flags = ^{psr_flags[WIDTH-1:8], psr_flags[5:0]};

  always_comb begin
    cond_true = 1'b0;
    case (A_index)
      4'b0000: cond_true = flag_z;
      4'b0001: cond_true = ~flag_z;
      4'b0110: cond_true = flag_n;
      4'b0111: cond_true = ~flag_n;
      4'b1100: cond_true = ~flag_n & ~flag_z;
      4'b1101: cond_true = flag_n | flag_z;
      4'b1110: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:  state <= S_LATCH;
        S_LATCH:  state <= S_DECODE;
        S_DECODE: begin
          if (is_alu)        state <= S_EXEC;
          else if (is_ld)    state <= S_LD;
          else if (is_st)    state <= S_ST;
          else if (is_jal)   state <= S_JAL;
          else if (is_jcond) state <= S_JCOND;
          else if (is_br)    state <= S_BR;
          else begin
`ifdef CTRL_HALT_EN
            state <= S_HALT;
`else
            state <= S_FETCH;
`endif
          end
        end
        S_LD:     state <= S_LD_WB;
        S_HALT:   state <= S_HALT;
        default:  state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    instruction_en = 1'b0;
    pc_en          = 1'b0;
    pc_src         = PC_INC;
    reg_write      = 1'b0;
    reg_write_src  = WB_ALU;
    alu_A_src      = 1'b0;
    alu_B_src      = 1'b0;
    alu_cont       = ALU_ADD;
    loading        = 1'b0;
    storing        = 1'b0;
    mem_write      = 1'b0;
    case (state)
      S_LATCH: instruction_en = 1'b1;
      S_DECODE: begin
        // JAL links from the unincremented PC, so the increment is withheld there.
`ifdef CTRL_HALT_EN
        pc_en = legal && !is_jal;
`else
        pc_en = !is_jal;
`endif
      end
      S_EXEC: begin
        alu_A_src = 1'b1;
        alu_B_src = is_imm;
        alu_cont  = exec_alu;
        reg_write = !is_cmp;
      end
      S_LD: loading = 1'b1;
      S_LD_WB: begin
        loading       = 1'b1;
        reg_write     = 1'b1;
        reg_write_src = WB_MEM;
      end
      S_ST: begin
        storing   = 1'b1;
        mem_write = 1'b1;
      end
      S_JAL: begin
        reg_write     = 1'b1;
        reg_write_src = WB_PC;
        pc_en         = 1'b1;
        pc_src        = PC_REGB;
      end
      S_JCOND: begin
        if (cond_true) begin
          pc_en  = 1'b1;
          pc_src = PC_REGB;
        end
      end
      S_BR: begin
        alu_A_src = 1'b0;
        alu_B_src = 1'b1;
        alu_cont  = ALU_ADD;
        if (cond_true) begin
          pc_en  = 1'b1;
          pc_src = PC_ALU;
        end
      end
      default: ;
    endcase
  end

`ifdef CTRL_HALT_EN
  assign halted = (state == S_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule
